// File: rtl/board_fetch_sched.sv
// board_fetch_sched
//   Owns the single-port board-cell RAM of the Tetris display. At every
//   hblank it turns the next scanline's Y into a board row by repeated
//   subtraction (no divider). It then bursts that row's cells into a line
//   buffer. During the active line it supplies the color of the cell under
//   the current pixel. Game logic is granted the RAM whenever no display
//   fetch is running.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   line_start, next_y  hblank pulse and the Y of the upcoming scanline
//   DrawX               current pixel column (may hold for several clocks)
//   cell_valid/color    registered cell lookup, one clock behind DrawX
//   gl_req/we/addr/     game-logic request port; gl_gnt is the one-cycle
//   gl_wdata/gl_gnt     grant, and the RAM access happens in that cycle
//   gl_rvalid/rdata     read return, one clock after a read grant
//   ram_addr/we/wdata   RAM command side
//   ram_rdata           synchronous RAM read data (one clock latency)
module board_fetch_sched #(
  parameter int BOARD_X0 = 160,
  parameter int CELL     = 26,
  parameter int COLS     = 12,
  parameter int ROWS     = 18
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       line_start,
  input  logic [9:0] next_y,
  input  logic [9:0] DrawX,
  output logic       cell_valid,
  output logic [2:0] cell_color,
  input  logic       gl_req,
  input  logic       gl_we,
  input  logic [7:0] gl_addr,
  input  logic [2:0] gl_wdata,
  output logic       gl_gnt,
  output logic       gl_rvalid,
  output logic [2:0] gl_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_we,
  output logic [2:0] ram_wdata,
  input  logic [2:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FETCH, DRAIN} state_t;

  localparam logic [9:0] X0       = 10'(BOARD_X0);
  localparam logic [9:0] CELL_Y   = 10'(CELL);
  localparam logic [4:0] SUB_LAST = 5'(CELL - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [7:0] COLS_A   = 8'(COLS);
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);

  state_t     state;
  logic [9:0] y_rem;
  logic [4:0] row;
  logic [7:0] base;
  logic [3:0] col_f;
  logic       row_loaded;
  logic [2:0] linebuf [COLS];

  // Fetch return tracking: a word issued in FETCH lands one clock later.
  logic       vld_p1;
  logic [3:0] idx_p1;
  logic       rd_p1;

  logic       gnt;

  // Column tracker
  logic [9:0] drawx_q;
  logic [3:0] col, col_n, col_rd;
  logic [4:0] sub, sub_n;
  logic       on_board, on_board_n;
  logic       vis;

  // ---- Stage p0: RAM command (grant or fetch address) ----
  // Game access is only possible in IDLE and never in the cycle a line
  // fetch is being kicked off, so the display always wins the hblank.
  always_comb begin
    gnt       = Reset_n && (state == IDLE) && gl_req && !line_start;
    ram_we    = 1'b0;
    ram_addr  = 8'd0;
    ram_wdata = 3'd0;
    if (gnt) begin
      ram_we    = gl_we;
      ram_addr  = gl_addr;
      ram_wdata = gl_wdata;
    end else if (state == FETCH) begin
      ram_addr = base + {4'd0, col_f};
    end
  end

  assign gl_gnt = gnt;

  // ---- Stage p1: RAM data return ----
  assign gl_rvalid = rd_p1;
  assign gl_rdata  = rd_p1 ? ram_rdata : 3'd0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      y_rem      <= 10'd0;
      row        <= 5'd0;
      base       <= 8'd0;
      col_f      <= 4'd0;
      row_loaded <= 1'b0;
      vld_p1     <= 1'b0;
      idx_p1     <= 4'd0;
      rd_p1      <= 1'b0;
      for (int i = 0; i < COLS; i++) linebuf[i] <= 3'd0;
    end else begin
      rd_p1  <= gnt && !gl_we;
      vld_p1 <= 1'b0;
      if (vld_p1) linebuf[idx_p1] <= ram_rdata;

      if (line_start) begin
        // A new scanline always restarts the row lookup, aborting any
        // fetch in flight; the old row is no longer valid for display.
        y_rem      <= next_y;
        row        <= 5'd0;
        base       <= 8'd0;
        col_f      <= 4'd0;
        row_loaded <= 1'b0;
        state      <= DIVIDE;
      end else begin
        case (state)
          IDLE: ;
          DIVIDE: begin
            if (y_rem >= CELL_Y) begin
              // Stop before row/base can step past the last board row so
              // the address never leaves the board.
              if (row == ROW_LAST) begin
                row_loaded <= 1'b0;
                state      <= IDLE;
              end else begin
                y_rem <= y_rem - CELL_Y;
                row   <= row + 5'd1;
                base  <= base + COLS_A;
              end
            end else begin
              col_f <= 4'd0;
              state <= FETCH;
            end
          end
          FETCH: begin
            vld_p1 <= 1'b1;
            idx_p1 <= col_f;
            if (col_f == COL_LAST) state <= DRAIN;
            else                   col_f <= col_f + 4'd1;
          end
          DRAIN: begin
            // The last word is written by the p1 path this same clock.
            row_loaded <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---- Stage p0: pixel to cell column ----
  // The column is advanced by counting DrawX changes instead of dividing,
  // so DrawX must step through every column from BOARD_X0 onward.
  always_comb begin
    col_n      = col;
    sub_n      = sub;
    on_board_n = on_board;
    if (DrawX < X0) begin
      on_board_n = 1'b0;
    end else if (DrawX == X0) begin
      col_n      = 4'd0;
      sub_n      = 5'd0;
      on_board_n = 1'b1;
    end else if ((DrawX != drawx_q) && on_board) begin
      if (sub == SUB_LAST) begin
        sub_n = 5'd0;
        col_n = col + 4'd1;
        if (col == COL_LAST) on_board_n = 1'b0;
      end else begin
        sub_n = sub + 5'd1;
      end
    end
    col_rd = (col_n > COL_LAST) ? COL_LAST : col_n;
    vis    = on_board_n && row_loaded && (state == IDLE);
  end

  // ---- Stage p1: registered cell output ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drawx_q    <= 10'd0;
      col        <= 4'd0;
      sub        <= 5'd0;
      on_board   <= 1'b0;
      cell_valid <= 1'b0;
      cell_color <= 3'd0;
    end else begin
      drawx_q    <= DrawX;
      col        <= col_n;
      sub        <= sub_n;
      on_board   <= on_board_n;
      cell_valid <= vis;
      cell_color <= vis ? linebuf[col_rd] : 3'd0;
    end
  end

endmodule
